// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encodings,
// byte-lane geometry and the word-to-byte-address helper.
package imem_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CHECK = 2'd2,
        ST_RUN   = 2'd3
    } state_t;

    localparam int LANES     = 4;
    localparam int LANE_BITS = 2;

    function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                   input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Host stream / IMem write / CPU control bundle of the loader.
// The host side uses the master modport, the loader the slave modport.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  Start;
    logic [ADDR_WIDTH:0]   WordCount;
    logic [7:0]            ByteIn;
    logic                  ByteValid;
    logic                  ByteReady;
    logic                  MemWrite;
    logic [31:0]           MemAddr;
    logic [31:0]           MemData;
    logic                  CPUReset;
    logic                  Busy;
    logic                  Done;
    logic                  Error;

    modport master (
        output Start, WordCount, ByteIn, ByteValid,
        input  ByteReady, MemWrite, MemAddr, MemData, CPUReset, Busy, Done, Error
    );

    modport slave (
        input  Start, WordCount, ByteIn, ByteValid,
        output ByteReady, MemWrite, MemAddr, MemData, CPUReset, Busy, Done, Error
    );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// 8->32 little-endian packer: byte k of a word lands in bits [8k+7:8k].
// word_valid_o pulses combinationally on the accept of the fourth byte.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        srst,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);
    logic [LANE_BITS-1:0]   lane_q;
    logic [8*(LANES-1)-1:0] held_bytes;

    always_ff @(posedge clk) begin
        if (srst || clear_i) begin
            lane_q <= '0;
        end else if (accept_i) begin
            lane_q <= lane_q + LANE_BITS'(1);
        end
    end

    // Only the lower three lanes are held; the top byte is taken straight
    // from the stream so the word is complete on the same edge.
    generate
        for (genvar gi = 0; gi < LANES - 1; gi++) begin : g_lane
            logic [7:0] byte_q;
            always_ff @(posedge clk) begin
                if (srst || clear_i) begin
                    byte_q <= '0;
                end else if (accept_i && (lane_q == LANE_BITS'(gi))) begin
                    byte_q <= byte_i;
                end
            end
            assign held_bytes[8*gi +: 8] = byte_q;
        end
    endgenerate

    assign word_valid_o = accept_i && (lane_q == LANE_BITS'(LANES - 1));
    assign word_o       = {byte_i, held_bytes};

endmodule

// File: rtl/imem_loader.sv
// Program loader: packs a byte stream into IMem words and holds the CPU in
// reset until the image is in. Define LOADER_CHECKSUM_EN for a trailing checksum word.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0
)
(
    input  logic Clk,
    input  logic Reset,
    imem_loader_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] MAX_WORDS = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] ONE_CNT   = (ADDR_WIDTH+1)'(1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   word_count_q, word_count_d;
    logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
    logic                  last_q, last_d;
    logic                  mem_write_q, mem_write_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic [31:0]           mem_data_q, mem_data_d;
    logic                  error_q, error_d;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]           sum_q, sum_d;
`endif

    logic        byte_ready;
    logic        accept;
    logic        word_valid;
    logic [31:0] packed_word;
    logic        packer_clear;
    logic        final_write;
    logic        count_ok;

    imem_loader_byte_packer u_packer (
        .clk          (Clk),
        .srst         (Reset),
        .clear_i      (packer_clear),
        .accept_i     (accept),
        .byte_i       (bus.ByteIn),
        .word_valid_o (word_valid),
        .word_o       (packed_word)
    );

    // The last word's write cycle closes the stream so no stray byte is taken.
    assign final_write = mem_write_q && last_q;
    assign byte_ready  = ((state_q == ST_LOAD) && !final_write) || (state_q == ST_CHECK);
    assign accept      = bus.ByteValid && byte_ready;
    assign count_ok    = (bus.WordCount != '0) && (bus.WordCount <= MAX_WORDS);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            word_count_q <= '0;
            word_idx_q   <= '0;
            last_q       <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            error_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            word_idx_q   <= word_idx_d;
            last_q       <= last_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            error_q      <= error_d;
`ifdef LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        word_idx_d   = word_idx_q;
        last_d       = last_q;
        mem_write_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        error_d      = error_q;
        packer_clear = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (bus.Start) begin
                    if (count_ok) begin
                        state_d      = ST_LOAD;
                        word_count_d = bus.WordCount;
                        word_idx_d   = '0;
                        last_d       = 1'b0;
                        error_d      = 1'b0;
                        packer_clear = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                        sum_d        = '0;
`endif
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (word_valid) begin
                    mem_write_d = 1'b1;
                    mem_addr_d  = word_byte_addr(BASE_ADDR, 32'(word_idx_q));
                    mem_data_d  = packed_word;
                    last_d      = ({1'b0, word_idx_q} == (word_count_q - ONE_CNT));
                    if (!last_d) begin
                        word_idx_d = word_idx_q + ADDR_WIDTH'(1);
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                if (mem_write_q) begin
                    sum_d = sum_q + mem_data_q;
                end
                if (final_write) begin
                    state_d = ST_CHECK;
                end
`else
                if (final_write) begin
                    state_d = ST_RUN;
                end
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (word_valid) begin
                    if (packed_word == sum_q) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_IDLE;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.ByteReady = byte_ready;
    assign bus.MemWrite  = mem_write_q;
    assign bus.MemAddr   = mem_addr_q;
    assign bus.MemData   = mem_data_q;
    assign bus.CPUReset  = (state_q != ST_RUN);
    assign bus.Busy      = (state_q == ST_LOAD) || (state_q == ST_CHECK);
    assign bus.Done      = (state_q == ST_RUN);
    assign bus.Error     = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table-driven images plus hand-written
// corner sequences; IMem writes are checked against a scoreboard queue.
module tb_imem_loader;

    localparam int          AW   = 8;
    localparam logic [31:0] BASE = 32'h0;

    typedef struct packed {
        logic [AW:0]       wc;
        logic [3:0][31:0]  words;
        logic              toggle;
        logic              auto_csum;
        logic [31:0]       csum;
        logic              exp_run;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_WIDTH(AW)) bus();

    imem_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb[$];
    logic [63:0] exp_wr;
    vec_t        vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.MemWrite !== 1'b0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: MemWrite=%b addr=0x%08h data=0x%08h, none expected",
                         bus.MemWrite, bus.MemAddr, bus.MemData);
            end else begin
                exp_wr = sb.pop_front();
                chk("write_addr", bus.MemAddr, exp_wr[63:32]);
                chk("write_data", bus.MemData, exp_wr[31:0]);
                $display("write addr=0x%08h data=0x%08h", bus.MemAddr, bus.MemData);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [AW:0] wc);
        bus.Start     = 1'b1;
        bus.WordCount = wc;
        tick();
        bus.Start     = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n = 0;
        bus.ByteIn    = b;
        bus.ByteValid = 1'b1;
        while (bus.ByteReady !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (bus.ByteReady !== 1'b1) begin
            chk("byte_ready_timeout", bus.ByteReady, 1);
            bus.ByteValid = 1'b0;
            return;
        end
        tick();
        bus.ByteValid = 1'b0;
        if (gap) tick();
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gap);
    endtask

    task automatic wait_done();
        int n = 0;
        while (bus.Done !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("done_reached", bus.Done, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cpureset"}, bus.CPUReset, 1);
        chk({tag, "_ready"},    bus.ByteReady, 0);
        chk({tag, "_memwrite"}, bus.MemWrite, 0);
        chk({tag, "_busy"},     bus.Busy, 0);
        chk({tag, "_done"},     bus.Done, 0);
        chk({tag, "_error"},    bus.Error, 0);
        chk({tag, "_addr"},     bus.MemAddr, 0);
        chk({tag, "_data"},     bus.MemData, 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] sum = '0;
        pulse_start(v.wc);
        chk("vec_busy", bus.Busy, 1);
        chk("vec_error_cleared", bus.Error, 0);
        chk("vec_cpureset_loading", bus.CPUReset, 1);
        for (int w = 0; w < int'(v.wc); w++) begin
            sb.push_back({BASE + 32'(4 * w), v.words[w]});
            sum = sum + v.words[w];
            send_word(v.words[w], v.toggle);
        end
`ifdef LOADER_CHECKSUM_EN
        send_word(v.auto_csum ? sum : v.csum, v.toggle);
`endif
        if (v.exp_run) begin
            wait_done();
            chk("vec_cpu_running", bus.CPUReset, 0);
            chk("vec_busy_low", bus.Busy, 0);
            chk("vec_error_low", bus.Error, 0);
        end else begin
            tick();
            tick();
            chk("vec_csum_error", bus.Error, 1);
            chk("vec_csum_cpureset", bus.CPUReset, 1);
            chk("vec_csum_done", bus.Done, 0);
            chk("vec_csum_busy", bus.Busy, 0);
        end
        chk("vec_sb_drained", 32'(sb.size()), 0);
        $display("vector %0d: wc=%0d toggle=%0d sum=0x%08h done=%0d error=%0d",
                 idx, v.wc, v.toggle, sum, bus.Done, bus.Error);
    endtask

    function automatic vec_t mk(input logic [AW:0] wc, input logic [3:0][31:0] words,
                                input logic toggle, input logic auto_csum,
                                input logic [31:0] csum, input logic exp_run);
        vec_t v;
        v.wc = wc; v.words = words; v.toggle = toggle;
        v.auto_csum = auto_csum; v.csum = csum; v.exp_run = exp_run;
        return v;
    endfunction

    initial begin
        logic [7:0] img[8];
        img = '{8'h13, 8'h00, 8'h08, 8'h20, 8'h0C, 8'h00, 8'h09, 8'h20};

        vecs.push_back(mk(9'd2, {32'h0, 32'h0, 32'h2009000C, 32'h20080013}, 1'b0, 1'b1, 32'h0, 1'b1));
        vecs.push_back(mk(9'd2, {32'h0, 32'h0, 32'h2009000C, 32'h20080013}, 1'b1, 1'b1, 32'h0, 1'b1));
        vecs.push_back(mk(9'd4, {32'h00000001, 32'hFFFFFFFF, 32'hA5A5A5A5, 32'h11223344}, 1'b0, 1'b1, 32'h0, 1'b1));
`ifdef LOADER_CHECKSUM_EN
        vecs.push_back(mk(9'd2, {32'h0, 32'h0, 32'h2, 32'h1}, 1'b0, 1'b0, 32'h3, 1'b1));
        vecs.push_back(mk(9'd2, {32'h0, 32'h0, 32'h2, 32'h1}, 1'b0, 1'b0, 32'h4, 1'b0));
`endif
        vecs.push_back(mk(9'd3, {32'h0, 32'hCAFEF00D, 32'h12345678, 32'h9ABCDEF0}, 1'b1, 1'b1, 32'h0, 1'b1));

        rst = 1'b1;
        bus.Start = 1'b0; bus.WordCount = '0; bus.ByteIn = '0; bus.ByteValid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_reset_outputs("reset");

        // Back-to-back two-word image with exact completion timing.
        pulse_start(9'd2);
        sb.push_back({BASE, 32'h20080013});
        sb.push_back({BASE + 32'd4, 32'h2009000C});
        for (int i = 0; i < 8; i++) send_byte(img[i], 1'b0);
        chk("t1_final_memwrite", bus.MemWrite, 1);
        chk("t1_ready_low", bus.ByteReady, 0);
        chk("t1_final_addr", bus.MemAddr, BASE + 32'd4);
        chk("t1_not_done_yet", bus.Done, 0);
        tick();
`ifdef LOADER_CHECKSUM_EN
        chk("t1_in_check", bus.Busy, 1);
        chk("t1_check_not_done", bus.Done, 0);
        send_word(32'h20080013 + 32'h2009000C, 1'b0);
        wait_done();
`else
        chk("t1_done", bus.Done, 1);
`endif
        chk("t1_cpureset", bus.CPUReset, 0);
        chk("t1_busy", bus.Busy, 0);
        $display("test1: two-word image loaded, done=%0d", bus.Done);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Restart from RUN.
        chk("t5_running", bus.Done, 1);
        pulse_start(9'd1);
        chk("t5_cpureset", bus.CPUReset, 1);
        chk("t5_done_low", bus.Done, 0);
        sb.push_back({BASE, 32'hDEADBEEF});
        send_word(32'hDEADBEEF, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'hDEADBEEF, 1'b0);
`endif
        wait_done();
        $display("test5: reload from RUN, done=%0d", bus.Done);

        // Reset mid-load after five bytes.
        pulse_start(9'd2);
        sb.push_back({BASE, 32'h44332211});
        for (int i = 0; i < 5; i++) send_byte(8'h11 * 8'(i + 1), 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_reset_outputs("t4");
        bus.ByteValid = 1'b1;
        bus.ByteIn    = 8'h66;
        repeat (10) tick();
        chk("t4_ready_stays_low", bus.ByteReady, 0);
        bus.ByteValid = 1'b0;
        chk("t4_sb_drained", 32'(sb.size()), 0);
        $display("test4: reset mid-load, cpureset=%0d", bus.CPUReset);

        // Illegal word counts, then a legal Start clears the error.
        pulse_start(9'd0);
        chk("t3_zero_error", bus.Error, 1);
        chk("t3_zero_cpureset", bus.CPUReset, 1);
        chk("t3_zero_busy", bus.Busy, 0);
        pulse_start(9'd257);
        chk("t3_big_error", bus.Error, 1);
        chk("t3_big_busy", bus.Busy, 0);
        repeat (3) tick();
        pulse_start(9'd1);
        chk("t3_error_cleared", bus.Error, 0);
        chk("t3_busy", bus.Busy, 1);
        sb.push_back({BASE, 32'h0BADF00D});
        send_word(32'h0BADF00D, 1'b1);
`ifdef LOADER_CHECKSUM_EN
        send_word(32'h0BADF00D, 1'b1);
`endif
        wait_done();
        $display("test3: illegal counts flagged, recovery done=%0d", bus.Done);

        chk("final_sb_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
